// File: rtl/mem_arbiter_if.sv
// Bus bundle tying the IF/LS pipeline ports and the unified memory port to the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_ack;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_stall;

    logic              i_ls_req;
    logic              i_ls_we;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic [MASK_W-1:0] i_ls_bmask;
    logic              o_ls_ack;
    logic [DATA_W-1:0] o_ls_rdata;
    logic              o_ls_stall;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [MASK_W-1:0] o_mem_bmask;
    logic              i_mem_ready;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_err;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_ack, o_if_rdata, o_if_stall,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_ack, o_ls_rdata, o_ls_stall,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_err
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_ack, o_if_rdata, o_if_stall,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_ack, o_ls_rdata, o_ls_stall,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and LS ports onto one single-port memory: registered command
// phase, then a read-response phase with timeout; acks/stalls go back to the pipeline.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LS_BURST_MAX = 2,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned MASK_W  = DATA_W / 8;
    localparam int unsigned BURST_W = $clog2(LS_BURST_MAX + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_CMD  = 3'd1,
        IF_WAIT = 3'd2,
        LS_CMD  = 3'd3,
        LS_WAIT = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]  mem_bmask_q, mem_bmask_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;

    logic accept_c, tmo_hit_c, rsp_c, if_ack_c, ls_ack_c;
    logic arb_c, grant_ls_c, grant_if_c;

    // Response-side decode; the timeout cycle wins over a late rvalid.
    always_comb begin
        accept_c  = mem_req_q & bus.i_mem_ready;
        tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT));
        rsp_c     = tmo_hit_c | bus.i_mem_rvalid;
        if_ack_c  = (state_q == IF_WAIT) & rsp_c;
        ls_ack_c  = ((state_q == LS_WAIT) & rsp_c) |
                    ((state_q == LS_CMD) & mem_we_q & accept_c);
    end

    assign bus.o_if_ack   = if_ack_c;
    assign bus.o_ls_ack   = ls_ack_c;
    assign bus.o_if_stall = bus.i_if_req & ~if_ack_c;
    assign bus.o_ls_stall = bus.i_ls_req & ~ls_ack_c;
    assign bus.o_if_rdata = ((state_q == IF_WAIT) && bus.i_mem_rvalid && !tmo_hit_c) ?
                            bus.i_mem_rdata : '0;
    assign bus.o_ls_rdata = ((state_q == LS_WAIT) && bus.i_mem_rvalid && !tmo_hit_c) ?
                            bus.i_mem_rdata : '0;

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_bmask = mem_bmask_q;
    assign bus.o_err       = err_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bmask_d = mem_bmask_q;
        burst_d     = burst_q;
        tmo_d       = tmo_q;
        err_d       = 1'b0;
        arb_c       = 1'b0;
        grant_ls_c  = 1'b0;
        grant_if_c  = 1'b0;

        case (state_q)
            IDLE: arb_c = 1'b1;
            IF_CMD, LS_CMD: begin
                if (accept_c) begin
                    if (mem_we_q) begin
                        arb_c = 1'b1;
                    end else begin
                        mem_req_d = 1'b0;
                        tmo_d     = '0;
                        state_d   = (state_q == IF_CMD) ? IF_WAIT : LS_WAIT;
                    end
                end
            end
            IF_WAIT, LS_WAIT: begin
                if (rsp_c) arb_c = 1'b1;
                else       tmo_d = tmo_q + TMO_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Completion cycles re-arbitrate directly so back-to-back accesses have no bubble.
        if (arb_c) begin
            tmo_d = '0;
            if (bus.i_ls_req && (burst_q < BURST_W'(LS_BURST_MAX))) grant_ls_c = 1'b1;
            else if (bus.i_if_req)                                  grant_if_c = 1'b1;
            else if (bus.i_ls_req)                                  grant_ls_c = 1'b1;
            else begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        end

        if (grant_ls_c) begin
            state_d     = LS_CMD;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.i_ls_we;
            mem_addr_d  = bus.i_ls_addr;
            mem_wdata_d = bus.i_ls_we ? bus.i_ls_wdata : '0;
            mem_bmask_d = bus.i_ls_we ? bus.i_ls_bmask : '1;
            if (bus.i_if_req) burst_d = burst_q + BURST_W'(1);
        end

        if (grant_if_c) begin
            state_d     = IF_CMD;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_if_addr;
            mem_wdata_d = '0;
            mem_bmask_d = '1;
            burst_d     = '0;
        end

        if (!bus.i_if_req) burst_d = '0;

        // Registered error pulse lines up with the timeout ack cycle.
        err_d = ((state_d == IF_WAIT) || (state_d == LS_WAIT)) && (tmo_d == TMO_W'(TIMEOUT));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            burst_q     <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            burst_q     <= burst_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end
endmodule
